ft232h_asynfifo_w_frame: RTL and testbench

Transmit side of the FT232H asynchronous 245-FIFO link: accepts one command byte plus one 32-bit word from the host-facing logic and writes them to the FT232H as an 8-byte frame with header and checksum. It sits next to the 5-byte FIFO reader on the same FT232H D[7:0] bus and provides the FPGA-to-PC direction. It drives the bus only while a byte write is in progress.

---
 rtl/ft232h_pkg.sv | 21 ++
 rtl/ft232h_sync2.sv | 25 ++
 rtl/ft232h_asynfifo_w_frame.sv | 158 +++++++++++++++
 tb/tb_ft232h_asynfifo_w_frame.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H 245-FIFO link: frame constants,
// transmit FSM state encoding and the frame checksum.
package ft232h_pkg;

   localparam int unsigned FRAME_LEN   = 8;
   localparam logic [7:0]  HEADER0_DEF = 8'hAB;
   localparam logic [7:0]  HEADER1_DEF = 8'hBA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TXE,
      ST_SETUP,
      ST_STROBE,
      ST_RELEASE
   } state_t;

   function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] data);
      return cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
   endfunction

endpackage

// File: rtl/ft232h_sync2.sv
// Generic 2-flop synchronizer for FT232H status pins (TXE#, RXF#).
// RST_VAL should be the pin's inactive level so reset never looks like "ready".
module ft232h_sync2 #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta   <= RST_VAL;
         o_sync <= RST_VAL;
      end else begin
         meta   <= i_async;
         o_sync <= meta;
      end
   end

endmodule

// File: rtl/ft232h_asynfifo_w_frame.sv
// FT232H async 245-FIFO transmitter: sends HEADER0, HEADER1, cmd, data[31:0]
// (MSB first) and an XOR checksum as one 8-byte frame, one WR# strobe per byte.
module ft232h_asynfifo_w_frame
   import ft232h_pkg::*;
#(
   parameter logic [7:0]  HEADER0   = HEADER0_DEF,
   parameter logic [7:0]  HEADER1   = HEADER1_DEF,
   parameter int unsigned SETUP_CLK = 1,
   parameter int unsigned HOLD_CLK  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_txe_n,
   output logic        o_wr_n,
   output logic [7:0]  o_data_out,
   output logic        o_data_oe,
   input  logic        i_start,
   input  logic [7:0]  i_cmd,
   input  logic [31:0] i_data,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned    PH_MAX     = (SETUP_CLK > HOLD_CLK) ? SETUP_CLK : HOLD_CLK;
   localparam int unsigned    PH_W       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CLK - 1);
   localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CLK - 1);
   localparam logic [2:0]     IDX_LAST   = 3'(FRAME_LEN - 1);

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            capture;
   logic            txe_s;

   logic [7:0]      cmd_q, chk_q;
   logic [31:0]     data_q;
   logic [7:0]      frame_byte;

   logic            wr_n_d, oe_d, busy_d, done_d;
   logic [7:0]      data_out_d;

   ft232h_sync2 #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_txe_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_txe_n),
      .o_sync  (txe_s)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         phase_q    <= '0;
         o_wr_n     <= 1'b1;
         o_data_oe  <= 1'b0;
         o_data_out <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         o_wr_n     <= wr_n_d;
         o_data_oe  <= oe_d;
         o_data_out <= data_out_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cmd_q  <= '0;
         data_q <= '0;
         chk_q  <= '0;
      end else if (capture) begin
         cmd_q  <= i_cmd;
         data_q <= i_data;
         chk_q  <= frame_chk(i_cmd, i_data);
      end
   end

   always_comb begin
      frame_byte = '0;
      case (idx_d)
         3'd0:    frame_byte = HEADER0;
         3'd1:    frame_byte = HEADER1;
         3'd2:    frame_byte = cmd_q;
         3'd3:    frame_byte = data_q[31:24];
         3'd4:    frame_byte = data_q[23:16];
         3'd5:    frame_byte = data_q[15:8];
         3'd6:    frame_byte = data_q[7:0];
         default: frame_byte = chk_q;
      endcase
   end

   // Outputs are decoded from the next state and registered, so the pins
   // change on the same edge as the state register.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      capture = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_WAIT_TXE;
               idx_d   = '0;
               capture = 1'b1;
            end
         end
         ST_WAIT_TXE: begin
            if (!txe_s) begin
               state_d = ST_SETUP;
               phase_d = '0;
            end
         end
         ST_SETUP: begin
            if (phase_q == SETUP_LAST) begin
               state_d = ST_STROBE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_STROBE: begin
            if (phase_q == HOLD_LAST) begin
               state_d = ST_RELEASE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_RELEASE: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_WAIT_TXE;
               idx_d   = idx_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      oe_d       = state_d inside {ST_SETUP, ST_STROBE, ST_RELEASE};
      wr_n_d     = (state_d != ST_STROBE);
      busy_d     = (state_d != ST_IDLE);
      data_out_d = oe_d ? frame_byte : 8'h00;
   end

endmodule

// File: tb/tb_ft232h_asynfifo_w_frame.sv
// Bench for ft232h_asynfifo_w_frame: default-timing DUT plus a SETUP_CLK=3 /
// HOLD_CLK=4 DUT, frames checked against a byte-level model of the link.
module tb_ft232h_asynfifo_w_frame;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        txe_n [2];
   logic        start [2];
   logic [7:0]  cmd   [2];
   logic [31:0] data  [2];
   logic        wr_n  [2];
   logic        oe    [2];
   logic        busy  [2];
   logic        done  [2];
   logic [7:0]  dout  [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   ft232h_asynfifo_w_frame dut (
      .i_clk(clk), .i_rst(rst), .i_txe_n(txe_n[0]), .o_wr_n(wr_n[0]),
      .o_data_out(dout[0]), .o_data_oe(oe[0]), .i_start(start[0]),
      .i_cmd(cmd[0]), .i_data(data[0]), .o_busy(busy[0]), .o_done(done[0])
   );

   ft232h_asynfifo_w_frame #(.SETUP_CLK(3), .HOLD_CLK(4)) dut_slow (
      .i_clk(clk), .i_rst(rst), .i_txe_n(txe_n[1]), .o_wr_n(wr_n[1]),
      .o_data_out(dout[1]), .o_data_oe(oe[1]), .i_start(start[1]),
      .i_cmd(cmd[1]), .i_data(data[1]), .o_busy(busy[1]), .o_done(done[1])
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: records each byte the chip would latch on WR# rising.
   logic       prev_wr  [2] = '{1'b1, 1'b1};
   logic       prev_oe  [2] = '{1'b0, 1'b0};
   logic       seen_low [2] = '{1'b0, 1'b0};
   logic [7:0] win_byte [2];
   int         cur_low  [2] = '{0, 0};
   int         pre      [2] = '{0, 0};
   int         got_n    [2] = '{0, 0};
   int         oe_bad   [2] = '{0, 0};
   int         unstable [2] = '{0, 0};
   int         done_cnt [2] = '{0, 0};
   logic [7:0] got_b     [2][128];
   int         low_len   [2][128];
   int         setup_len [2][128];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (oe[g]) begin
            if (!prev_oe[g]) win_byte[g] <= dout[g];
            else if (dout[g] !== win_byte[g]) unstable[g] <= unstable[g] + 1;
            if (wr_n[g] && !seen_low[g]) pre[g] <= pre[g] + 1;
         end else begin
            pre[g] <= 0;
         end
         if (!oe[g]) seen_low[g] <= 1'b0;
         else if (!wr_n[g]) seen_low[g] <= 1'b1;
         if (!wr_n[g]) begin
            cur_low[g] <= cur_low[g] + 1;
            if (!oe[g]) oe_bad[g] <= oe_bad[g] + 1;
         end else if (!prev_wr[g] && got_n[g] < 128) begin
            got_b[g][got_n[g]]     <= dout[g];
            low_len[g][got_n[g]]   <= cur_low[g];
            setup_len[g][got_n[g]] <= pre[g];
            got_n[g]               <= got_n[g] + 1;
            cur_low[g]             <= 0;
         end
         if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
         prev_wr[g] <= wr_n[g];
         prev_oe[g] <= oe[g];
      end
   end

   function automatic logic [7:0] exp_byte(input logic [7:0] c, input logic [31:0] d, input int i);
      logic [7:0] f [8];
      logic [7:0] x;
      f[0] = 8'hAB;
      f[1] = 8'hBA;
      f[2] = c;
      for (int k = 0; k < 4; k++) f[3+k] = 8'(d >> (24 - 8*k));
      x = '0;
      for (int k = 2; k < 7; k++) x = x ^ f[k];
      f[7] = x;
      return f[i];
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame(input int g, input logic [7:0] c, input logic [31:0] d, output int n0);
      cmd[g]   = c;
      data[g]  = d;
      start[g] = 1'b1;
      n0       = cyc + 1;
      tick();
      start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget);
      int t = 0;
      while (!done[g] && t < budget) begin
         tick();
         t++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      for (int g = 0; g < 2; g++) begin
         checks++;
         if ({wr_n[g], oe[g], dout[g], busy[g], done[g]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: wr_n=%b oe=%b dout=%h busy=%b done=%b, want 1 0 00 0 0",
                     g, wr_n[g], oe[g], dout[g], busy[g], done[g]);
         end
      end
      rst = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_basic();
      int n0, base, ob, us, bad;
      base = got_n[0]; ob = oe_bad[0]; us = unstable[0];
      start_frame(0, 8'h55, 32'h12345678, n0);
      checks++;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy[0]); end
      tick();
      checks++;
      if (wr_n[0] !== 1'b1 || oe[0] !== 1'b1) begin
         errors++; $display("FAIL basic_setup_n1: wr_n=%b oe=%b want 1 1", wr_n[0], oe[0]);
      end
      tick();
      checks++;
      if (wr_n[0] !== 1'b0) begin errors++; $display("FAIL basic_first_fall_n2: wr_n=%b want 0", wr_n[0]); end
      wait_done(0, 100);
      checks++;
      if (!done[0] || cyc - n0 != 40) begin
         errors++; $display("FAIL basic_done_latency: got %0d want 40 (done=%b)", cyc - n0, done[0]);
      end
      checks++;
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy[0]); end
      tick();
      checks++;
      if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done[0]); end
      checks++;
      if (got_n[0] - base != 8) begin errors++; $display("FAIL basic_byte_count: got %0d want 8", got_n[0] - base); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got_b[0][base+i] !== exp_byte(8'h55, 32'h12345678, i)) begin
            errors++;
            $display("FAIL basic_byte%0d: got %h want %h", i, got_b[0][base+i], exp_byte(8'h55, 32'h12345678, i));
         end
      end
      bad = 0;
      for (int i = 0; i < 8; i++) if (low_len[0][base+i] != 2 || setup_len[0][base+i] != 1) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL basic_strobe_timing: %0d bytes off, want WR# low 2 and setup 1", bad); end
      checks++;
      if (oe_bad[0] != ob || unstable[0] != us) begin
         errors++; $display("FAIL basic_bus_integrity: oe_bad=%0d unstable=%0d want 0 0", oe_bad[0] - ob, unstable[0] - us);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         int n0, base, bad;
         logic [7:0]  c;
         logic [31:0] d;
         c = 8'($urandom);
         d = $urandom;
         repeat ($urandom_range(0, 3)) tick();
         base = got_n[0];
         start_frame(0, c, d, n0);
         wait_done(0, 100);
         checks++;
         if (!done[0] || cyc - n0 != 40) begin
            errors++; $display("FAIL random%0d_latency: got %0d want 40", f, cyc - n0);
         end
         bad = (got_n[0] - base == 8) ? 0 : 8;
         for (int i = 0; i < 8; i++) if (got_b[0][base+i] !== exp_byte(c, d, i)) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL random%0d_bytes: %0d wrong for cmd=%h data=%h", f, bad, c, d);
         end
      end
      tick();
   endtask

   task automatic test_txe_wait();
      int n0, base, act, r, t, bad;
      txe_n[0] = 1'b1;
      repeat (3) tick();
      base = got_n[0];
      start_frame(0, 8'hC3, 32'hDEADBEEF, n0);
      act = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (oe[0] !== 1'b0 || wr_n[0] !== 1'b1) act++;
      end
      checks++;
      if (act != 0 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL txe_hold_quiet: active cycles=%0d busy=%b want 0 1", act, busy[0]);
      end
      txe_n[0] = 1'b0;
      r = cyc + 1;
      t = 0;
      while (!oe[0] && t < 20) begin tick(); t++; end
      checks++;
      if (!oe[0] || cyc - r != 2) begin
         errors++; $display("FAIL txe_release_latency: oe after %0d want 2", cyc - r);
      end
      r = cyc;
      wait_done(0, 100);
      checks++;
      if (!done[0] || cyc - r != 39) begin
         errors++; $display("FAIL txe_frame_time: got %0d want 39", cyc - r);
      end
      bad = (got_n[0] - base == 8) ? 0 : 8;
      for (int i = 0; i < 8; i++) if (got_b[0][base+i] !== exp_byte(8'hC3, 32'hDEADBEEF, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL txe_bytes: %0d wrong want 0", bad); end
      tick();
   endtask

   task automatic test_stall();
      int n0, base, t, r, expd, bad;
      logic [7:0]  c;
      logic [31:0] d;
      c = 8'($urandom);
      d = $urandom;
      base = got_n[0];
      start_frame(0, c, d, n0);
      t = 0;
      while (!(got_n[0] - base == 3 && wr_n[0] == 1'b0) && t < 50) begin tick(); t++; end
      txe_n[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i == 9) begin
            checks++;
            if (got_n[0] - base != 4 || oe[0] !== 1'b0 || busy[0] !== 1'b1) begin
               errors++;
               $display("FAIL stall_waiting: bytes=%0d oe=%b busy=%b want 4 0 1", got_n[0] - base, oe[0], busy[0]);
            end
         end
      end
      txe_n[0] = 1'b0;
      r = cyc + 1;
      // byte 4 would nominally enter SETUP at edge n0+21; it now does so 2 edges after TXE# is seen low
      expd = 40 + (r + 2) - (n0 + 21);
      wait_done(0, 200);
      checks++;
      if (!done[0] || cyc - n0 != expd) begin
         errors++; $display("FAIL stall_latency: got %0d want %0d", cyc - n0, expd);
      end
      bad = (got_n[0] - base == 8) ? 0 : 8;
      for (int i = 0; i < 8; i++) if (got_b[0][base+i] !== exp_byte(c, d, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_bytes: %0d wrong want 0", bad); end
      tick();
   endtask

   task automatic test_ignore_b2b();
      int n0, n1, base, bad;
      base = got_n[0];
      start_frame(0, 8'hA1, 32'h01020304, n0);
      repeat (9) tick();
      cmd[0]   = 8'h5A;
      data[0]  = 32'hFFFF0000;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wait_done(0, 100);
      checks++;
      if (!done[0] || cyc - n0 != 40) begin
         errors++; $display("FAIL ignore_latency: got %0d want 40", cyc - n0);
      end
      cmd[0]   = 8'h3C;
      data[0]  = 32'hCAFEF00D;
      start[0] = 1'b1;
      n1       = cyc + 1;
      tick();
      start[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy[0]); end
      wait_done(0, 100);
      checks++;
      if (!done[0] || cyc - n1 != 40) begin
         errors++; $display("FAIL b2b_latency: got %0d want 40", cyc - n1);
      end
      bad = (got_n[0] - base == 16) ? 0 : 16;
      for (int i = 0; i < 8; i++) if (got_b[0][base+i] !== exp_byte(8'hA1, 32'h01020304, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ignore_bytes: %0d wrong want 0", bad); end
      bad = 0;
      for (int i = 0; i < 8; i++) if (got_b[0][base+8+i] !== exp_byte(8'h3C, 32'hCAFEF00D, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_bytes: %0d wrong want 0", bad); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n0, base, dc, t, bad;
      base = got_n[0];
      dc   = done_cnt[0];
      start_frame(0, 8'h77, 32'h89ABCDEF, n0);
      t = 0;
      while (!(got_n[0] - base == 5 && wr_n[0] == 1'b0) && t < 60) begin tick(); t++; end
      rst = 1'b1;
      tick();
      checks++;
      if (wr_n[0] !== 1'b1 || oe[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 8'h00) begin
         errors++;
         $display("FAIL midreset_outputs: wr_n=%b oe=%b busy=%b dout=%h want 1 0 0 00", wr_n[0], oe[0], busy[0], dout[0]);
      end
      rst = 1'b0;
      repeat (6) tick();
      checks++;
      if (done_cnt[0] != dc || busy[0] !== 1'b0) begin
         errors++; $display("FAIL midreset_no_done: done pulses=%0d busy=%b want 0 0", done_cnt[0] - dc, busy[0]);
      end
      base = got_n[0];
      start_frame(0, 8'h10, 32'h2030405A, n0);
      wait_done(0, 100);
      checks++;
      if (!done[0] || cyc - n0 != 40) begin
         errors++; $display("FAIL midreset_refresh_latency: got %0d want 40", cyc - n0);
      end
      bad = (got_n[0] - base == 8) ? 0 : 8;
      for (int i = 0; i < 8; i++) if (got_b[0][base+i] !== exp_byte(8'h10, 32'h2030405A, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL midreset_refresh_bytes: %0d wrong want 0", bad); end
      tick();
   endtask

   task automatic test_slow_params();
      int n0, base, us, bad;
      logic [7:0]  c;
      logic [31:0] d;
      c = 8'($urandom);
      d = $urandom;
      base = got_n[1];
      us   = unstable[1];
      start_frame(1, c, d, n0);
      wait_done(1, 200);
      checks++;
      if (!done[1] || cyc - n0 != 72) begin
         errors++; $display("FAIL slow_latency: got %0d want 72", cyc - n0);
      end
      bad = (got_n[1] - base == 8) ? 0 : 8;
      for (int i = 0; i < 8; i++) if (got_b[1][base+i] !== exp_byte(c, d, i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL slow_bytes: %0d wrong want 0", bad); end
      bad = 0;
      for (int i = 0; i < 8; i++) if (low_len[1][base+i] != 4 || setup_len[1][base+i] != 3) bad++;
      checks++;
      if (bad != 0 || unstable[1] != us) begin
         errors++; $display("FAIL slow_strobe_timing: %0d bytes off, unstable=%0d want 0 0", bad, unstable[1] - us);
      end
      tick();
   endtask

   initial begin
      rst   = 1'b1;
      txe_n = '{1'b0, 1'b0};
      start = '{1'b0, 1'b0};
      cmd   = '{8'h00, 8'h00};
      data  = '{32'h0, 32'h0};
      test_reset();
      test_basic();
      test_random_frames();
      test_txe_wait();
      test_stall();
      test_ignore_b2b();
      test_reset_mid();
      test_slow_params();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
